// File: rtl/fifo_buffer_v3_if.sv
// Handshake/data bundle for fifo_buffer_v3: the slave modport is the FIFO side,
// the master modport is the producer/consumer side that drives the requests.
interface fifo_buffer_v3_if #(
  parameter int DATA_WIDTH = 36,
  parameter int ADDR_WIDTH = 5
);
  logic                  clear_i;
  logic [DATA_WIDTH-1:0] data_i;
  logic                  wren_i;
  logic                  rden_i;
  logic [DATA_WIDTH-1:0] data_o;
  logic                  valid_o;
  logic                  empty_o;
  logic                  full_o;
  logic                  almost_full_o;
  logic [ADDR_WIDTH:0]   count_o;
  logic                  overflow_o;
  logic                  underflow_o;

  modport slave (
    input  clear_i, data_i, wren_i, rden_i,
    output data_o, valid_o, empty_o, full_o, almost_full_o, count_o,
           overflow_o, underflow_o
  );

  modport master (
    output clear_i, data_i, wren_i, rden_i,
    input  data_o, valid_o, empty_o, full_o, almost_full_o, count_o,
           overflow_o, underflow_o
  );
endinterface

// File: rtl/fifo_buffer_v3.sv
// Single-clock circular FIFO, 2**ADDR_WIDTH deep; read latency 1 cycle (FWFT=0) or 0 (FWFT=1).
// No backpressure stall: rejected writes/reads are dropped and latched into sticky overflow/underflow flags.
module fifo_buffer_v3 #(
  parameter int DATA_WIDTH   = 36,
  parameter int ADDR_WIDTH   = 5,
  parameter int AFULL_THRESH = 28,
  parameter bit FWFT         = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  fifo_buffer_v3_if.slave  bus
);

  localparam int              DEPTH   = 1 << ADDR_WIDTH;
  localparam int              CW      = ADDR_WIDTH + 1;
  localparam logic [CW-1:0]   DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0]   AFULL_C = CW'(AFULL_THRESH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;
  logic                  valid_q, valid_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;

  logic rd_acc;
  logic wr_acc;
  logic mem_we;

  // A full FIFO can still take a write when a read frees the slot in the same cycle.
  always_comb begin
    rd_acc = bus.rden_i && (count_q != '0);
    wr_acc = bus.wren_i && ((count_q != DEPTH_C) || rd_acc);
    mem_we = wr_acc && !bus.clear_i;
  end

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    valid_d     = 1'b0;
    data_d      = data_q;

    if (bus.clear_i) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
      data_d      = '0;
    end else begin
      if (wr_acc) begin
        wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (rd_acc) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end

      case ({wr_acc, rd_acc})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase

      if (bus.wren_i && !wr_acc) begin
        overflow_d = 1'b1;
      end
      if (bus.rden_i && !rd_acc) begin
        underflow_d = 1'b1;
      end

      // Registered read port is only used in the non-FWFT mode.
      if (!FWFT && rd_acc) begin
        valid_d = 1'b1;
        data_d  = mem[rd_ptr_q];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
      valid_q     <= 1'b0;
      data_q      <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
      valid_q     <= valid_d;
      data_q      <= data_d;
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[wr_ptr_q] <= bus.data_i;
    end
  end

  assign bus.empty_o       = (count_q == '0);
  assign bus.full_o        = (count_q == DEPTH_C);
  assign bus.almost_full_o = (count_q >= AFULL_C);
  assign bus.count_o       = count_q;
  assign bus.overflow_o    = overflow_q;
  assign bus.underflow_o   = underflow_q;

  generate
    if (FWFT) begin : g_fwft
      // Head word shown straight from storage; forced to zero while empty so reset/clear read as 0.
      assign bus.valid_o = (count_q != '0);
      assign bus.data_o  = (count_q != '0) ? mem[rd_ptr_q] : '0;
    end else begin : g_reg
      assign bus.valid_o = valid_q;
      assign bus.data_o  = data_q;
    end
  endgenerate

endmodule

// File: tb/tb_fifo_buffer_v3.sv
// Directed bench for fifo_buffer_v3: one registered-read and one FWFT instance driven in lockstep.
module tb_fifo_buffer_v3;

  localparam int DW = 36;
  localparam int AW = 5;

  logic clk;
  logic reset;

  int n_tests = 0;
  int n_fail  = 0;

  fifo_buffer_v3_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) if0 ();
  fifo_buffer_v3_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) if1 ();

  fifo_buffer_v3 #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .AFULL_THRESH(28), .FWFT(1'b0)) u_reg (
    .clk   (clk),
    .reset (reset),
    .bus   (if0.slave)
  );

  fifo_buffer_v3 #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .AFULL_THRESH(28), .FWFT(1'b1)) u_fwft (
    .clk   (clk),
    .reset (reset),
    .bus   (if1.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic wr, input logic rd, input logic clr, input logic [DW-1:0] d);
    if0.wren_i = wr;  if0.rden_i = rd;  if0.clear_i = clr;  if0.data_i = d;
    if1.wren_i = wr;  if1.rden_i = rd;  if1.clear_i = clr;  if1.data_i = d;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    drive(1'b0, 1'b0, 1'b0, '0);
    #12;
    chk("rst_count", if0.count_o, 0);
    chk("rst_empty", if0.empty_o, 1);
    chk("rst_full", if0.full_o, 0);
    chk("rst_afull", if0.almost_full_o, 0);
    chk("rst_valid", if0.valid_o, 0);
    chk("rst_data", if0.data_o, 0);
    chk("rst_ovf", if0.overflow_o, 0);
    chk("rst_unf", if0.underflow_o, 0);
    chk("rst_fwft_valid", if1.valid_o, 0);
    chk("rst_fwft_data", if1.data_o, 0);
    reset = 1'b0;

    // Fill 0x00..0x1F; almost_full from count 28
    for (int i = 0; i < 32; i++) begin
      drive(1'b1, 1'b0, 1'b0, DW'(i));
      tick();
      chk("fill_count", if0.count_o, i + 1);
      chk("fill_afull", if0.almost_full_o, (i + 1) >= 28);
      chk("fill_full", if0.full_o, (i + 1) == 32);
      if (i == 0) begin
        chk("fwft_first_valid", if1.valid_o, 1);
        chk("fwft_first_data", if1.data_o, 0);
        chk("reg_no_valid_on_write", if0.valid_o, 0);
      end
    end
    drive(1'b1, 1'b0, 1'b0, 36'h99);
    tick();
    chk("ovf_set", if0.overflow_o, 1);
    chk("ovf_count", if0.count_o, 32);
    chk("ovf_unf_clear", if0.underflow_o, 0);

    // Drain in order, one cycle read latency
    for (int i = 0; i < 32; i++) begin
      drive(1'b0, 1'b1, 1'b0, '0);
      tick();
      chk("drain_valid", if0.valid_o, 1);
      chk("drain_data", if0.data_o, i);
      chk("drain_count", if0.count_o, 31 - i);
    end
    chk("drain_empty", if0.empty_o, 1);
    drive(1'b0, 1'b0, 1'b0, '0);
    tick();
    chk("idle_valid", if0.valid_o, 0);
    chk("idle_data_hold", if0.data_o, 31);
    chk("pre_unf", if0.underflow_o, 0);
    drive(1'b0, 1'b1, 1'b0, '0);
    tick();
    chk("unf_set", if0.underflow_o, 1);
    chk("unf_valid", if0.valid_o, 0);
    chk("unf_count", if0.count_o, 0);

    drive(1'b0, 1'b0, 1'b1, '0);
    tick();
    chk("clr_ovf", if0.overflow_o, 0);
    chk("clr_unf", if0.underflow_o, 0);
    chk("clr_data", if0.data_o, 0);

    // Full FIFO, simultaneous read+write across pointer wrap
    for (int i = 0; i < 32; i++) begin
      drive(1'b1, 1'b0, 1'b0, DW'(36'h100 + i));
      tick();
    end
    chk("wrap_prefull", if0.full_o, 1);
    for (int k = 0; k < 40; k++) begin
      drive(1'b1, 1'b1, 1'b0, DW'(36'h120 + k));
      tick();
      chk("wrap_data", if0.data_o, 36'h100 + k);
      chk("wrap_count", if0.count_o, 32);
      chk("wrap_valid", if0.valid_o, 1);
    end
    chk("wrap_no_ovf", if0.overflow_o, 0);
    chk("wrap_fwft_head", if1.data_o, 36'h128);
    chk("wrap_fwft_count", if1.count_o, 32);
    drive(1'b0, 1'b0, 1'b1, '0);
    tick();

    // Empty FIFO with simultaneous read+write
    drive(1'b1, 1'b1, 1'b0, 36'hA5);
    tick();
    chk("erw_unf", if0.underflow_o, 1);
    chk("erw_count", if0.count_o, 1);
    chk("erw_reg_valid", if0.valid_o, 0);
    chk("erw_fwft_valid", if1.valid_o, 1);
    chk("erw_fwft_data", if1.data_o, 36'hA5);
    chk("erw_fwft_unf", if1.underflow_o, 1);
    drive(1'b0, 1'b0, 1'b1, '0);
    tick();

    // Clear at count 10 together with a write
    drive(1'b0, 1'b1, 1'b0, '0);
    tick();
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 1'b0, 1'b0, DW'(36'h200 + i));
      tick();
    end
    chk("c10_count", if0.count_o, 10);
    chk("c10_unf", if0.underflow_o, 1);
    drive(1'b1, 1'b0, 1'b1, 36'h3C);
    tick();
    chk("clrw_count", if0.count_o, 0);
    chk("clrw_empty", if0.empty_o, 1);
    chk("clrw_unf", if0.underflow_o, 0);
    chk("clrw_ovf", if0.overflow_o, 0);
    drive(1'b0, 1'b0, 1'b0, '0);
    tick();
    chk("clrw_dropped", if0.count_o, 0);
    chk("clrw_fwft_valid", if1.valid_o, 0);

    // Asynchronous reset in the middle of a burst
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b0, 1'b0, DW'(36'h300 + i));
      tick();
    end
    for (int k = 0; k < 2; k++) begin
      drive(1'b1, 1'b1, 1'b0, DW'(36'h305 + k));
      tick();
    end
    chk("burst_data", if0.data_o, 36'h301);
    chk("burst_count", if0.count_o, 5);
    #3;
    reset = 1'b1;
    #1;
    chk("arst_count", if0.count_o, 0);
    chk("arst_empty", if0.empty_o, 1);
    chk("arst_valid", if0.valid_o, 0);
    chk("arst_data", if0.data_o, 0);
    chk("arst_fwft_valid", if1.valid_o, 0);
    chk("arst_fwft_data", if1.data_o, 0);
    drive(1'b0, 1'b0, 1'b0, '0);
    #1;
    reset = 1'b0;
    drive(1'b1, 1'b0, 1'b0, 36'h77);
    tick();
    chk("resume_count", if0.count_o, 1);
    drive(1'b0, 1'b1, 1'b0, '0);
    tick();
    chk("resume_data", if0.data_o, 36'h77);
    chk("resume_valid", if0.valid_o, 1);
    drive(1'b0, 1'b0, 1'b0, '0);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
